// File: rtl/serial_add_arbiter_if.sv
// Request/operand/result bundle between two add requesters and the shared
// bit-serial adder. The master side drives requests; the slave side is the adder.
interface serial_add_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             cin0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             cin1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output req0, a0, b0, cin0, req1, a1, b1, cin1,
        input  gnt0, gnt1, busy, done, done_id, sum, cout
    );

    modport slave (
        input  req0, a0, b0, cin0, req1, a1, b1, cin1,
        output gnt0, gnt1, busy, done, done_id, sum, cout
    );
endinterface

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter in front of a single 1-bit full adder that performs
// LSB-first WIDTH-bit additions for two requesters, one at a time.
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_add_arbiter_if.slave  bus
);
    localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             last_q,   last_d;
    logic             owner_q,  owner_d;
    logic             gnt0_q,   gnt0_d;
    logic             gnt1_q,   gnt1_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             done_id_q, done_id_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    logic [1:0]       fa_s;
    logic [WIDTH:0]   res_ext_s;
    logic             win0_s;

    // Returns {carry_out, sum} of one full-adder bit.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Next-state, datapath sequencing and output pulse generation.
    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        res_sr_d  = res_sr_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;

        fa_s      = full_add(a_sr_q[0], b_sr_q[0], carry_q);
        res_ext_s = {fa_s[0], res_sr_q};
        // Requester 0 wins when alone, or when both ask and 1 was served last.
        win0_s    = bus.req0 & (~bus.req1 | last_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    owner_d = ~win0_s;
                    last_d  = ~win0_s;
                    if (win0_s) begin
                        a_sr_d  = bus.a0;
                        b_sr_d  = bus.b0;
                        carry_d = bus.cin0;
                        gnt0_d  = 1'b1;
                    end else begin
                        a_sr_d  = bus.a1;
                        b_sr_d  = bus.b1;
                        carry_d = bus.cin1;
                        gnt1_d  = 1'b1;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                a_sr_d   = a_sr_q >> 1'b1;
                b_sr_d   = b_sr_q >> 1'b1;
                res_sr_d = res_ext_s[WIDTH:1];
                carry_d  = fa_s[1];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    sum_d     = res_ext_s[WIDTH:1];
                    cout_d    = fa_s[1];
                    done_id_d = owner_q;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_sr_q    <= {WIDTH{1'b0}};
            b_sr_q    <= {WIDTH{1'b0}};
            res_sr_q  <= {WIDTH{1'b0}};
            carry_q   <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            sum_q     <= {WIDTH{1'b0}};
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            res_sr_q  <= res_sr_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.sum     = sum_q;
    assign bus.cout    = cout_q;
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench: an 8-bit and a 1-bit instance, expected results queued at
// request time and consumed by per-instance monitors on each done pulse.
module tb_serial_add_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_add_arbiter_if #(.WIDTH(8)) b8 ();
    serial_add_arbiter_if #(.WIDTH(1)) b1 ();

    serial_add_arbiter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    serial_add_arbiter #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    typedef struct packed {
        logic       id;
        logic       cout;
        logic [7:0] sum;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    exp_t e8;
    exp_t e1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (b8.gnt0 && b8.gnt1) begin
            checks++; errors++;
            $display("FAIL gnt8_both: gnt0 and gnt1 high together");
        end
        if (b8.done === 1'b1) begin
            chk("done8_no_gnt", {30'd0, b8.gnt0, b8.gnt1}, 32'd0);
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL done8_unexpected: sum=%0h cout=%0b id=%0b", b8.sum, b8.cout, b8.done_id);
            end else begin
                e8 = q8.pop_front();
                chk("sum8", {24'd0, b8.sum}, {24'd0, e8.sum});
                chk("cout8", {31'd0, b8.cout}, {31'd0, e8.cout});
                chk("done_id8", {31'd0, b8.done_id}, {31'd0, e8.id});
            end
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        if (b1.done === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL done1_unexpected: sum=%0b cout=%0b", b1.sum, b1.cout);
            end else begin
                e1 = q1.pop_front();
                chk("fa1_cout_sum", {30'd0, b1.cout, b1.sum}, {30'd0, e1.cout, e1.sum[0]});
            end
        end
    end

    task automatic wait_gnt8(output int id, output int gc);
        id = -1;
        gc = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (b8.gnt0) begin id = 0; gc = cyc; break; end
            if (b8.gnt1) begin id = 1; gc = cyc; break; end
        end
        if (id < 0) begin
            checks++; errors++;
            $display("FAIL gnt8_timeout: no grant within 40 cycles");
        end
    endtask

    task automatic wait_idle8();
        int t;
        t = 0;
        while (b8.busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            checks++; errors++;
            $display("FAIL idle8_timeout: busy stuck high");
        end
        @(negedge clk);
    endtask

    task automatic req8(input int id, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, output int gc);
        int g;
        if (id == 0) begin
            b8.a0 = a; b8.b0 = b; b8.cin0 = c; b8.req0 = 1'b1;
        end else begin
            b8.a1 = a; b8.b1 = b; b8.cin1 = c; b8.req1 = 1'b1;
        end
        q8.push_back('{id: id[0], cout: ec, sum: es});
        wait_gnt8(g, gc);
        chk("gnt8_id", g, id);
        if (id == 0) b8.req0 = 1'b0;
        else         b8.req1 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset8(input string nm);
        chk(nm, {20'd0, b8.gnt0, b8.gnt1, b8.busy, b8.done, b8.done_id, b8.cout, b8.sum},
            32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gc, g, bc, dc, prev;
        logic [1:0] tt [8];
        tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        b8.req0 = 1'b0; b8.req1 = 1'b0;
        b8.a0 = 8'h00; b8.b0 = 8'h00; b8.cin0 = 1'b0;
        b8.a1 = 8'h00; b8.b1 = 8'h00; b8.cin1 = 1'b0;
        b1.req0 = 1'b0; b1.req1 = 1'b0;
        b1.a0 = 1'b0; b1.b0 = 1'b0; b1.cin0 = 1'b0;
        b1.a1 = 1'b0; b1.b1 = 1'b0; b1.cin1 = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset8("reset8_state");
        chk("reset1_state", {25'd0, b1.gnt0, b1.gnt1, b1.busy, b1.done, b1.done_id, b1.cout, b1.sum},
            32'd0);

        // 1: 0x5A + 0x33, latency and busy duration.
        req8(0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, gc);
        bc = 0; dc = 0;
        for (int t = 0; t < 40; t++) begin
            if (!b8.busy) break;
            bc++;
            if (b8.done) dc = cyc;
            @(negedge clk);
        end
        chk("busy_cycles", bc, 9);
        chk("grant_to_done", dc - gc, 8);
        chk("gnt8_after_op", {30'd0, b8.gnt0, b8.gnt1}, 32'd0);

        // 2: overflow into cout, including carry-in.
        req8(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, gc);
        wait_idle8();
        req8(1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, gc);
        wait_idle8();

        // 3: both held after reset alternate 0,1,0,1 spaced WIDTH+2 apart.
        do_reset();
        b8.a0 = 8'h5A; b8.b0 = 8'h33; b8.cin0 = 1'b0;
        b8.a1 = 8'h10; b8.b1 = 8'h20; b8.cin1 = 1'b0;
        b8.req0 = 1'b1; b8.req1 = 1'b1;
        q8.push_back('{id: 1'b0, cout: 1'b0, sum: 8'h8D});
        q8.push_back('{id: 1'b1, cout: 1'b0, sum: 8'h30});
        q8.push_back('{id: 1'b0, cout: 1'b0, sum: 8'h8D});
        q8.push_back('{id: 1'b1, cout: 1'b0, sum: 8'h30});
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt8(g, gc);
            chk("rr_order", g, k % 2);
            if (k > 0) chk("rr_spacing", gc - prev, 10);
            prev = gc;
        end
        b8.req0 = 1'b0; b8.req1 = 1'b0;
        wait_idle8();

        // 4: operand change after grant is ignored.
        req8(0, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, gc);
        repeat (2) @(negedge clk);
        b8.a0 = 8'h00;
        wait_idle8();

        // 5: reset at RUN edge 4 aborts; pointer returns so requester 0 wins.
        b8.a0 = 8'h12; b8.b0 = 8'h34; b8.cin0 = 1'b0; b8.req0 = 1'b1;
        wait_gnt8(g, gc);
        chk("abort_gnt_id", g, 0);
        b8.req0 = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        chk_reset8("abort_reset_state");
        repeat (12) @(negedge clk);
        chk("abort_idle", {31'd0, b8.busy}, 32'd0);
        b8.a0 = 8'h01; b8.b0 = 8'h02; b8.cin0 = 1'b0;
        b8.a1 = 8'h80; b8.b1 = 8'h80; b8.cin1 = 1'b1;
        q8.push_back('{id: 1'b0, cout: 1'b0, sum: 8'h03});
        q8.push_back('{id: 1'b1, cout: 1'b1, sum: 8'h01});
        b8.req0 = 1'b1; b8.req1 = 1'b1;
        wait_gnt8(g, gc);
        chk("post_reset_first", g, 0);
        b8.req0 = 1'b0;
        wait_gnt8(g, gc);
        chk("post_reset_second", g, 1);
        b8.req1 = 1'b0;
        wait_idle8();

        // 6: WIDTH=1 full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            b1.a0 = i[2]; b1.b0 = i[1]; b1.cin0 = i[0];
            q1.push_back('{id: 1'b0, cout: tt[i][1], sum: {7'd0, tt[i][0]}});
            b1.req0 = 1'b1;
            gc = -1;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (b1.gnt0) begin gc = cyc; break; end
            end
            b1.req0 = 1'b0;
            dc = -1;
            for (int t = 0; t < 20; t++) begin
                if (b1.done) begin dc = cyc; break; end
                @(negedge clk);
            end
            chk("w1_latency", dc - gc, 1);
            repeat (2) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_add_arbiter.md
Name: serial_add_arbiter

Overview:
- Shares one 1-bit full-adder cell between two requesters by running a bit-serial, LSB-first addition of WIDTH-bit operands.
- Provides round-robin arbitration, operand latching, carry sequencing and result delivery.
- Sits above the combinational full-adder and mux cells and is the block that schedules them.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)

Ports:
clk  in  1  single system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset, sampled on rising clk
req0  in  1  requester 0 add request, held until gnt0
a0  in  WIDTH  requester 0 operand A
b0  in  WIDTH  requester 0 operand B
cin0  in  1  requester 0 carry-in
req1  in  1  requester 1 add request, held until gnt1
a1  in  WIDTH  requester 1 operand A
b1  in  WIDTH  requester 1 operand B
cin1  in  1  requester 1 carry-in
gnt0  out  1  one-cycle pulse: requester 0 operands latched
gnt1  out  1  one-cycle pulse: requester 1 operands latched
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse: sum/cout valid
done_id  out  1  requester that owns the current result (0/1)
sum  out  WIDTH  registered result, held until next done
cout  out  1  registered carry-out, held until next done

Behaviour:
- Reset:
  - state=IDLE.
  - gnt0=gnt1=busy=done=done_id=0, sum=0, cout=0.
  - Bit counter=0, carry flop=0.
  - Round-robin pointer last=1, so requester 0 wins first.
- States: IDLE, RUN, DONE.
- IDLE:
  - At a rising edge with req0|req1, pick a winner:
    - If only one requests, that one wins.
    - If both request, the requester != last wins.
  - Latch the winner's a, b and cin into shift registers and the carry flop, and set owner=winner.
  - gnt<winner>=1 for exactly the next cycle; last=winner; counter=0; go to RUN.
  - With no request, stay in IDLE and keep all pulses 0.
- RUN:
  - Each edge computes one full-adder bit from a_sr[0], b_sr[0] and the carry flop.
  - The sum bit shifts into the MSB of the result shift register; the carry flop takes the bit carry-out.
  - a_sr and b_sr shift right; counter increments.
  - On the edge that processes bit WIDTH-1:
    - sum <= completed shift value; cout <= final carry; done_id <= owner.
    - done=1 for the following cycle; go to DONE.
- DONE: one cycle with done=1, then IDLE at the next edge.
- Latency: grant edge to done-high cycle = WIDTH edges. Request-to-request throughput = WIDTH+2 cycles.
- Input changes:
  - Operand and req changes after the grant edge have no effect on the running operation.
  - A requester still asserting req when the block returns to IDLE is treated as a new request.
  - Under continuous req0 and req1, grants alternate 0,1,0,1.
  - A req dropped before its grant edge is never granted. No grant is ever issued outside IDLE.
- Result outputs:
  - sum, cout and done_id change only on the edge that raises done, and are otherwise stable.
  - gnt0 and gnt1 are never high together. done and gnt are never high together.
- Reset mid-operation:
  - Abort immediately, with no done pulse; all outputs and pointer return to reset values.
  - The pending requester must be regranted.
- Width rules:
  - All arithmetic is modulo 2^WIDTH; the overflow appears only on cout.
  - WIDTH=1 degenerates to a single full-adder evaluation: done follows the grant edge after 1 RUN edge.

Test Plan:
1. WIDTH=8, req0 with a0=0x5A, b0=0x33, cin0=0 -> gnt0 pulse 1 cycle; done 8 edges later; sum=0x8D, cout=0, done_id=0; busy high for 9 cycles.
2. WIDTH=8, req1 with a1=0xFF, b1=0x01, cin1=0 -> sum=0x00, cout=1, done_id=1. Then a1=0xFF, b1=0x00, cin1=1 -> sum=0x00, cout=1.
3. After reset, req0 and req1 asserted together and held -> grant order 0,1,0,1. Results are 0x5A+0x33=0x8D for 0 and 0x10+0x20=0x30 for 1, with matching done_id. Grants are spaced WIDTH+2 cycles apart.
4. Start a0=0xAA, b0=0x55 and change a0 to 0x00 two cycles after gnt0 -> sum=0xFF, cout=0; the change is ignored.
5. Assert rst for one cycle at RUN edge 4 -> no done pulse; busy=0, sum=0, cout=0. A new req0 then completes normally and is granted first.
6. WIDTH=1, apply all 8 (a,b,cin) combinations via req0 -> each {cout,sum} equals the full-adder truth table: 00, 01, 01, 10, 01, 10, 10, 11.
